// File: rtl/seg_frame_sequencer.sv
// rtl/seg_frame_sequencer.sv - frame sequencer for the hand-segmentation datapath
//
// Purpose:
//   Tracks pixel position within each camera frame and decides, frame by frame,
//   whether the segmenter applies skin thresholds or background difference.
//   In background-difference mode it discards settling frames, captures one
//   full frame into the luma background RAM, then strobes compares on every
//   later frame.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pix_valid         one pixel present this cycle
//   frame_start       qualifies pix_valid as pixel 0 of a new frame
//   mode_bg_diff      1 = background difference, 0 = skin threshold (sampled at frame_start)
//   recapture         single-cycle request to re-acquire the background
//   bg_addr           background RAM address of the reported pixel
//   bg_we             write the pixel's luma into background RAM
//   cmp_en            compare the pixel's luma against background
//   skin_en           apply skin thresholds to the pixel
//   pix_x, pix_y      column / row of the reported pixel
//   frame_done        pulse on the last pixel of a frame
//   bg_ready          a complete background is stored
//   overrun           sticky: pixel arrived past frame end without frame_start
//   state             IDLE=0, SETTLE=1, CAPTURE=2, RUN=3

module seg_frame_sequencer #(
  parameter int FRAME_W       = 160,
  parameter int FRAME_H       = 120,
  parameter int SETTLE_FRAMES = 2,
  parameter int ADDR_W        = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              frame_start,
  input  logic              mode_bg_diff,
  input  logic              recapture,
  output logic [ADDR_W-1:0] bg_addr,
  output logic              bg_we,
  output logic              cmp_en,
  output logic              skin_en,
  output logic [7:0]        pix_x,
  output logic [6:0]        pix_y,
  output logic              frame_done,
  output logic              bg_ready,
  output logic              overrun,
  output logic [1:0]        state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  localparam int              N_PIX    = FRAME_W * FRAME_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PIX - 1);
  localparam logic [7:0]      LAST_X   = 8'(FRAME_W - 1);

  localparam int              SC_W          = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);
  localparam logic [SC_W-1:0] SETTLE_TARGET = SC_W'(SETTLE_FRAMES);

  // With no settle frames the background is captured on the very next frame.
  localparam logic [1:0] SETTLE_ENTRY = (SETTLE_FRAMES == 0) ? S_CAPTURE : S_SETTLE;

  logic [1:0]        r_state;
  logic [SC_W-1:0]   r_settle_cnt;
  logic              r_started;
  logic              r_bg_mode;
  logic              r_bg_ready;
  logic              r_pending;
  logic              r_overrun;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_x;
  logic [6:0]        r_y;
  logic              r_bg_we;
  logic              r_cmp_en;
  logic              r_skin_en;
  logic              r_frame_done;

  logic              w_cap_done;
  logic              w_bg_valid;
  logic [1:0]        w_cur_state;
  logic              w_pend;
  logic              w_sof;
  logic              w_at_end;
  logic              w_cont;
  logic              w_over;
  logic              w_accept;
  logic [1:0]        w_sof_state;
  logic              w_sof_use_pend;
  logic              w_sof_clr_ready;
  logic              w_cnt_keep;
  logic [1:0]        w_pix_state;
  logic              w_pix_bg_mode;
  logic [ADDR_W-1:0] w_idx_n;
  logic [7:0]        w_x_n;
  logic [6:0]        w_y_n;
  logic              w_last_pix;
  logic [SC_W-1:0]   w_cnt_base;
  logic [SC_W-1:0]   w_cnt_next;

  // A capture completes on the cycle after its last pixel is reported, so
  // bg_ready and the RUN state appear one cycle after frame_done. A frame_start
  // landing in that same cycle must already see the completed background.
  assign w_cap_done  = r_frame_done & r_bg_we;
  assign w_bg_valid  = r_bg_ready | w_cap_done;
  assign w_cur_state = w_cap_done ? S_RUN : r_state;
  assign w_pend      = r_pending | recapture;

  assign w_sof    = pix_valid & frame_start;
  assign w_at_end = (r_idx == LAST_IDX);
  assign w_cont   = pix_valid & ~frame_start & r_started & ~w_at_end;
  assign w_over   = pix_valid & ~frame_start & r_started & w_at_end;
  assign w_accept = w_sof | w_cont;

  // State chosen for the frame that begins with this frame_start.
  always_comb begin
    w_sof_state     = w_cur_state;
    w_sof_use_pend  = 1'b0;
    w_sof_clr_ready = 1'b0;
    if (!mode_bg_diff) begin
      w_sof_state = S_RUN;
    end else if (w_pend) begin
      w_sof_use_pend  = 1'b1;
      w_sof_clr_ready = 1'b1;
      // A recapture while still capturing just restarts the capture.
      if (w_cur_state == S_CAPTURE) begin
        w_sof_state = S_CAPTURE;
      end else begin
        w_sof_state = SETTLE_ENTRY;
      end
    end else begin
      case (w_cur_state)
        S_IDLE:    w_sof_state = SETTLE_ENTRY;
        S_SETTLE:  w_sof_state = (r_settle_cnt == SETTLE_TARGET) ? S_CAPTURE : S_SETTLE;
        S_CAPTURE: w_sof_state = S_CAPTURE;
        default:   w_sof_state = w_bg_valid ? S_RUN : SETTLE_ENTRY;
      endcase
    end
  end

  // The settle count survives a frame_start only when settling simply continues.
  assign w_cnt_keep = (w_sof_state == S_SETTLE) && (w_cur_state == S_SETTLE) && !w_sof_use_pend;

  assign w_pix_state   = w_sof ? w_sof_state : w_cur_state;
  assign w_pix_bg_mode = w_sof ? mode_bg_diff : r_bg_mode;

  always_comb begin
    w_idx_n = '0;
    w_x_n   = '0;
    w_y_n   = '0;
    if (!w_sof) begin
      w_idx_n = r_idx + 1'b1;
      if (r_x == LAST_X) begin
        w_x_n = '0;
        w_y_n = r_y + 1'b1;
      end else begin
        w_x_n = r_x + 1'b1;
        w_y_n = r_y;
      end
    end
  end

  assign w_last_pix = w_accept && (w_idx_n == LAST_IDX);
  assign w_cnt_base = (w_sof && !w_cnt_keep) ? '0 : r_settle_cnt;

  // Settling frames are counted only when they run to completion.
  always_comb begin
    w_cnt_next = w_cnt_base;
    if (w_last_pix && (w_pix_state == S_SETTLE) && (w_cnt_base != SETTLE_TARGET)) begin
      w_cnt_next = w_cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_started    <= 1'b0;
      r_bg_mode    <= 1'b0;
      r_bg_ready   <= 1'b0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_idx        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_bg_we      <= 1'b0;
      r_cmp_en     <= 1'b0;
      r_skin_en    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_bg_we      <= 1'b0;
      r_cmp_en     <= 1'b0;
      r_skin_en    <= 1'b0;
      r_frame_done <= 1'b0;
      r_state      <= w_cur_state;
      r_bg_ready   <= w_bg_valid;
      r_settle_cnt <= w_cnt_next;

      if (recapture) begin
        r_pending <= 1'b1;
      end
      if (w_over) begin
        r_overrun <= 1'b1;
      end

      if (w_sof) begin
        r_started <= 1'b1;
        r_state   <= w_sof_state;
        r_bg_mode <= mode_bg_diff;
        if (w_sof_use_pend) begin
          r_pending <= 1'b0;
        end
        if (w_sof_clr_ready) begin
          r_bg_ready <= 1'b0;
        end
      end

      if (w_accept) begin
        r_idx        <= w_idx_n;
        r_x          <= w_x_n;
        r_y          <= w_y_n;
        r_bg_we      <= (w_pix_state == S_CAPTURE);
        r_cmp_en     <= (w_pix_state == S_RUN) &  w_pix_bg_mode;
        r_skin_en    <= (w_pix_state == S_RUN) & ~w_pix_bg_mode;
        r_frame_done <= w_last_pix;
      end
    end
  end

  assign bg_addr    = r_idx;
  assign pix_x      = r_x;
  assign pix_y      = r_y;
  assign bg_we      = r_bg_we;
  assign cmp_en     = r_cmp_en;
  assign skin_en    = r_skin_en;
  assign frame_done = r_frame_done;
  assign bg_ready   = r_bg_ready;
  assign overrun    = r_overrun;
  assign state      = r_state;

endmodule

// File: tb/tb_seg_frame_sequencer.sv
// tb/tb_seg_frame_sequencer.sv - self-checking bench for seg_frame_sequencer
module tb_seg_frame_sequencer;

  localparam int W  = 24;
  localparam int H  = 10;
  localparam int SF = 2;
  localparam int AW = 15;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic          frame_start;
  logic          mode_bg_diff;
  logic          recapture;
  logic [AW-1:0] bg_addr;
  logic          bg_we;
  logic          cmp_en;
  logic          skin_en;
  logic [7:0]    pix_x;
  logic [6:0]    pix_y;
  logic          frame_done;
  logic          bg_ready;
  logic          overrun;
  logic [1:0]    state;

  always #5 clk = ~clk;

  seg_frame_sequencer #(
    .FRAME_W(W), .FRAME_H(H), .SETTLE_FRAMES(SF), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
    .mode_bg_diff(mode_bg_diff), .recapture(recapture), .bg_addr(bg_addr),
    .bg_we(bg_we), .cmp_en(cmp_en), .skin_en(skin_en), .pix_x(pix_x),
    .pix_y(pix_y), .frame_done(frame_done), .bg_ready(bg_ready),
    .overrun(overrun), .state(state)
  );

  logic [37:0] dut_vec;
  assign dut_vec = {state, overrun, bg_ready, frame_done, pix_y, pix_x,
                    skin_en, cmp_en, bg_we, bg_addr};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame roles 0 idle, 1 settle, 2 capture, 3 run.
  bit m_started, m_bgmode, m_ready, m_pend, m_over, m_cap_fin;
  bit m_we, m_cmp, m_skin, m_done;
  int m_idx, m_role, m_settle;

  task automatic model_reset();
    m_started = 0; m_bgmode = 0; m_ready = 0; m_pend = 0; m_over = 0; m_cap_fin = 0;
    m_we = 0; m_cmp = 0; m_skin = 0; m_done = 0;
    m_idx = 0; m_role = 0; m_settle = 0;
  endtask

  task automatic enter_settle();
    m_settle = 0;
    m_role   = (SF == 0) ? 2 : 1;
  endtask

  task automatic model_pixel();
    m_we   = (m_role == 2);
    m_cmp  = (m_role == 3) && m_bgmode;
    m_skin = (m_role == 3) && !m_bgmode;
    if (m_idx == N - 1) begin
      m_done = 1;
      if (m_role == 1 && m_settle < SF) m_settle++;
      if (m_role == 2) m_cap_fin = 1;
    end
  endtask

  task automatic model_step(input bit pv, input bit fs, input bit md, input bit rc);
    m_we = 0; m_cmp = 0; m_skin = 0; m_done = 0;
    if (m_cap_fin) begin
      m_role = 3; m_ready = 1; m_cap_fin = 0;
    end
    if (rc) m_pend = 1;
    if (pv && fs) begin
      m_started = 1; m_idx = 0; m_bgmode = md;
      if (!md) m_role = 3;
      else if (m_pend) begin
        m_pend = 0; m_ready = 0;
        if (m_role != 2) enter_settle();
      end else if (m_role == 0) enter_settle();
      else if (m_role == 1) begin
        if (m_settle >= SF) m_role = 2;
      end else if (m_role == 3 && !m_ready) enter_settle();
      model_pixel();
    end else if (pv && m_started) begin
      if (m_idx == N - 1) m_over = 1;
      else begin
        m_idx++;
        model_pixel();
      end
    end
  endtask

  function automatic logic [37:0] model_vec();
    logic [6:0]    y;
    logic [7:0]    x;
    logic [AW-1:0] a;
    logic [1:0]    r;
    y = 7'(m_idx / W);
    x = 8'(m_idx % W);
    a = AW'(m_idx);
    r = 2'(m_role);
    return {r, m_over, m_ready, m_done, y, x, m_skin, m_cmp, m_we, a};
  endfunction

  // Directed observation counters
  bit md;
  int cnt_we, cnt_cmp, cnt_skin, contig_err, next_cmp;
  int done_addr, x_at_w, y_at_w, x_last, y_last;

  task automatic clear_counts();
    cnt_we = 0; cnt_cmp = 0; cnt_skin = 0; contig_err = 0; next_cmp = 0;
    done_addr = -1; x_at_w = -1; y_at_w = -1; x_last = -1; y_last = -1;
  endtask

  task automatic observe();
    if (bg_we) cnt_we++;
    if (skin_en) cnt_skin++;
    if (cmp_en) begin
      if (int'(bg_addr) != next_cmp) contig_err++;
      next_cmp = int'(bg_addr) + 1;
      cnt_cmp++;
    end
    if (frame_done) done_addr = int'(bg_addr);
    if (bg_we | cmp_en | skin_en) begin
      if (int'(bg_addr) == W) begin x_at_w = int'(pix_x); y_at_w = int'(pix_y); end
      if (int'(bg_addr) == N - 1) begin x_last = int'(pix_x); y_last = int'(pix_y); end
    end
  endtask

  task automatic cycle(input bit pv, input bit fs, input bit rc);
    pix_valid = pv; frame_start = fs; mode_bg_diff = md; recapture = rc;
    model_step(pv, fs, md, rc);
    @(posedge clk); #1;
    check("outputs", 64'(dut_vec), 64'(model_vec()));
    observe();
    @(negedge clk);
  endtask

  task automatic send_frame(input int from, input int to, input int gap_pct,
                            input int rc_at, input int flip_at);
    for (int i = from; i < to; i++) begin
      while (int'($urandom_range(99)) < gap_pct) cycle(0, 0, 0);
      if (i == flip_at) md = ~md;
      cycle(1, i == 0, i == rc_at);
    end
  endtask

  task automatic apply_reset();
    rst = 1; pix_valid = 0; frame_start = 0; recapture = 0;
    model_reset();
    @(posedge clk); #1;
    check("reset_outputs", 64'(dut_vec), 64'd0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; pix_valid = 0; frame_start = 0; mode_bg_diff = 0; recapture = 0; md = 1;
    clear_counts();
    @(negedge clk);
    apply_reset();

    // Pixels before the first frame_start are ignored
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    check("pre_sof_state", 64'(state), 64'd0);
    check("pre_sof_strobes", 64'({bg_we, cmp_en, skin_en}), 64'd0);

    // Two settle frames then a capture frame
    md = 1;
    clear_counts();
    send_frame(0, N, 20, -1, -1);
    send_frame(0, N, 0, -1, -1);
    check("settle_no_strobes", 64'(cnt_we + cnt_cmp + cnt_skin), 64'd0);
    clear_counts();
    send_frame(0, N, 0, -1, -1);
    check("capture_we_count", 64'(cnt_we), 64'(N));
    check("capture_done_addr", 64'(done_addr), 64'(N - 1));
    check("ready_low_at_done", 64'(bg_ready), 64'd0);
    cycle(0, 0, 0);
    check("ready_after_capture", 64'(bg_ready), 64'd1);
    check("state_run", 64'(state), 64'd3);

    // Compare frame with gaps
    clear_counts();
    send_frame(0, N, 30, -1, -1);
    check("cmp_count", 64'(cnt_cmp), 64'(N));
    check("cmp_contiguous", 64'(contig_err), 64'd0);
    check("cmp_no_we", 64'(cnt_we + cnt_skin), 64'd0);
    check("x_at_w", 64'(x_at_w), 64'd0);
    check("y_at_w", 64'(y_at_w), 64'd1);
    check("x_last", 64'(x_last), 64'(W - 1));
    check("y_last", 64'(y_last), 64'(H - 1));

    // Recapture mid-run: compare finishes, then settle, settle, capture
    clear_counts();
    send_frame(0, N, 10, N / 2, -1);
    check("recap_cmp_count", 64'(cnt_cmp), 64'(N));
    check("recap_ready_held", 64'(bg_ready), 64'd1);
    send_frame(0, 1, 0, -1, -1);
    check("recap_ready_clr", 64'(bg_ready), 64'd0);
    check("recap_state_settle", 64'(state), 64'd1);
    send_frame(1, N, 10, -1, -1);
    send_frame(0, N, 10, -1, -1);

    // Truncated capture restarts on the new frame
    send_frame(0, 100, 0, -1, -1);
    check("trunc_state_capture", 64'(state), 64'd2);
    clear_counts();
    send_frame(0, 1, 0, -1, -1);
    check("trunc_addr_zero", 64'(bg_addr), 64'd0);
    check("trunc_ready_low", 64'(bg_ready), 64'd0);
    send_frame(1, N, 10, -1, -1);
    check("trunc_full_we", 64'(cnt_we), 64'(N));
    cycle(0, 0, 0);
    check("trunc_ready_after", 64'(bg_ready), 64'd1);

    // Pixel past the end without frame_start
    cycle(1, 0, 0);
    check("overrun_set", 64'(overrun), 64'd1);
    check("overrun_no_strobe", 64'({bg_we, cmp_en, skin_en}), 64'd0);
    check("overrun_addr_hold", 64'(bg_addr), 64'(N - 1));

    // Skin mode from reset, mode toggled mid-frame
    apply_reset();
    md = 0;
    clear_counts();
    send_frame(0, N, 10, -1, N / 3);
    check("skin_count", 64'(cnt_skin), 64'(N));
    check("skin_no_bg", 64'(cnt_we + cnt_cmp), 64'd0);
    send_frame(0, 50, 10, -1, -1);
    check("skin_to_bg_settle", 64'(state), 64'd1);

    // Reset mid-frame aborts immediately
    apply_reset();
    check("reset_state_idle", 64'(state), 64'd0);

    // Randomized traffic against the model
    md = 1'($urandom_range(1));
    for (int i = 0; i < 4000; i++) begin
      bit pv, fs, rc;
      pv = ($urandom_range(3) != 0);
      fs = pv && ($urandom_range(299) == 0);
      rc = ($urandom_range(399) == 0);
      if ($urandom_range(499) == 0) md = ~md;
      cycle(pv, fs, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
